// File: rtl/int_entry.sv
// -----------------------------------------------------------------------------
// int_entry -- interrupt entry sequencer.
//
// Takes a latched FIQ/IRQ request at an instruction boundary and runs a fixed
// four-cycle entry sequence:
//   ACK    : one-cycle INTA_fiq / INTA_irq pulse
//   SAVE   : banked SPSR <- CPSR, banked LR <- Ret_addr + 4
//   SWITCH : CPSR <- new mode, IRQ (and FIQ) masked, Thumb cleared
//   JUMP   : PC <- exception vector, fetch flushed
// Stall is high for the whole sequence. FIQ wins over IRQ; a losing or
// blocked request is simply left pending at the request stage.
//
// Configuration macro:
//   INT_HIVEC_EN  defined   -> vector base 32'hFFFF0000
//                 undefined -> vector base 32'h00000000
//
// Ports:
//   clk, Rst_n            clock, asynchronous active-low reset
//   INT_irq, INT_fiq      latched requests
//   CPSR, Ret_addr        live status register, next-instruction address
//   Instr_boundary        pipeline may be interrupted this cycle
//   INTA_irq, INTA_fiq    acknowledge pulses
//   Stall                 pipeline freeze
//   SPSR_we/mode/data     banked SPSR write
//   LR_we/LR_data         banked LR write
//   CPSR_we/CPSR_new      CPSR write
//   PC_we/PC_vector/Flush fetch redirect
// All outputs are registered; data outputs are zero when their enable is low.
// -----------------------------------------------------------------------------
module int_entry (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic        INT_irq,
    input  logic        INT_fiq,
    input  logic [31:0] CPSR,
    input  logic [31:0] Ret_addr,
    input  logic        Instr_boundary,
    output logic        INTA_irq,
    output logic        INTA_fiq,
    output logic        Stall,
    output logic        SPSR_we,
    output logic [4:0]  SPSR_mode,
    output logic [31:0] SPSR_data,
    output logic        LR_we,
    output logic [31:0] LR_data,
    output logic        CPSR_we,
    output logic [31:0] CPSR_new,
    output logic        PC_we,
    output logic [31:0] PC_vector,
    output logic        Flush
);

`ifdef INT_HIVEC_EN
    localparam logic [31:0] VEC_BASE = 32'hFFFF0000;
`else
    localparam logic [31:0] VEC_BASE = 32'h00000000;
`endif

    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        ACK    = 5'b00010,
        SAVE   = 5'b00100,
        SWITCH = 5'b01000,
        JUMP   = 5'b10000
    } state_t;

    state_t      state_q, state_d;
    logic        is_fiq_q, is_fiq_d;
    logic [31:0] cpsr_q, cpsr_d;
    logic [31:0] ret_q, ret_d;

    logic        inta_irq_q, inta_irq_d;
    logic        inta_fiq_q, inta_fiq_d;
    logic        stall_q, stall_d;
    logic        spsr_we_q, spsr_we_d;
    logic [4:0]  spsr_mode_q, spsr_mode_d;
    logic [31:0] spsr_data_q, spsr_data_d;
    logic        lr_we_q, lr_we_d;
    logic [31:0] lr_data_q, lr_data_d;
    logic        cpsr_we_q, cpsr_we_d;
    logic [31:0] cpsr_new_q, cpsr_new_d;
    logic        pc_we_q, pc_we_d;
    logic [31:0] pc_vector_q, pc_vector_d;
    logic        flush_q, flush_d;

    logic        take_fiq, take_irq;
    logic [4:0]  mode_d;

    assign take_fiq = INT_fiq && !CPSR[6];
    assign take_irq = INT_irq && !CPSR[7];

    // Next state and context latch
    always_comb begin
        state_d  = state_q;
        is_fiq_d = is_fiq_q;
        cpsr_d   = cpsr_q;
        ret_d    = ret_q;
        case (state_q)
            IDLE: begin
                if (Instr_boundary && (take_fiq || take_irq)) begin
                    state_d  = ACK;
                    is_fiq_d = take_fiq;
                    cpsr_d   = CPSR;
                    ret_d    = Ret_addr;
                end
            end
            ACK:     state_d = SAVE;
            SAVE:    state_d = SWITCH;
            SWITCH:  state_d = JUMP;
            JUMP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and latched context so that
    // the registered outputs line up with the state they belong to.
    always_comb begin
        mode_d      = is_fiq_d ? MODE_FIQ : MODE_IRQ;
        inta_irq_d  = 1'b0;
        inta_fiq_d  = 1'b0;
        stall_d     = 1'b0;
        spsr_we_d   = 1'b0;
        spsr_mode_d = '0;
        spsr_data_d = '0;
        lr_we_d     = 1'b0;
        lr_data_d   = '0;
        cpsr_we_d   = 1'b0;
        cpsr_new_d  = '0;
        pc_we_d     = 1'b0;
        pc_vector_d = '0;
        flush_d     = 1'b0;
        case (state_d)
            ACK: begin
                stall_d    = 1'b1;
                inta_fiq_d = is_fiq_d;
                inta_irq_d = !is_fiq_d;
            end
            SAVE: begin
                stall_d     = 1'b1;
                spsr_we_d   = 1'b1;
                spsr_mode_d = mode_d;
                spsr_data_d = cpsr_d;
                lr_we_d     = 1'b1;
                lr_data_d   = ret_d + 32'd4;
            end
            SWITCH: begin
                stall_d    = 1'b1;
                cpsr_we_d  = 1'b1;
                // I always set; F set only on FIQ entry; T cleared.
                cpsr_new_d = {cpsr_d[31:8], 1'b1, (is_fiq_d | cpsr_d[6]), 1'b0, mode_d};
            end
            JUMP: begin
                stall_d     = 1'b1;
                pc_we_d     = 1'b1;
                flush_d     = 1'b1;
                pc_vector_d = VEC_BASE + (is_fiq_d ? 32'h0000001C : 32'h00000018);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            is_fiq_q    <= 1'b0;
            cpsr_q      <= '0;
            ret_q       <= '0;
            inta_irq_q  <= 1'b0;
            inta_fiq_q  <= 1'b0;
            stall_q     <= 1'b0;
            spsr_we_q   <= 1'b0;
            spsr_mode_q <= '0;
            spsr_data_q <= '0;
            lr_we_q     <= 1'b0;
            lr_data_q   <= '0;
            cpsr_we_q   <= 1'b0;
            cpsr_new_q  <= '0;
            pc_we_q     <= 1'b0;
            pc_vector_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_fiq_q    <= is_fiq_d;
            cpsr_q      <= cpsr_d;
            ret_q       <= ret_d;
            inta_irq_q  <= inta_irq_d;
            inta_fiq_q  <= inta_fiq_d;
            stall_q     <= stall_d;
            spsr_we_q   <= spsr_we_d;
            spsr_mode_q <= spsr_mode_d;
            spsr_data_q <= spsr_data_d;
            lr_we_q     <= lr_we_d;
            lr_data_q   <= lr_data_d;
            cpsr_we_q   <= cpsr_we_d;
            cpsr_new_q  <= cpsr_new_d;
            pc_we_q     <= pc_we_d;
            pc_vector_q <= pc_vector_d;
            flush_q     <= flush_d;
        end
    end

    assign INTA_irq  = inta_irq_q;
    assign INTA_fiq  = inta_fiq_q;
    assign Stall     = stall_q;
    assign SPSR_we   = spsr_we_q;
    assign SPSR_mode = spsr_mode_q;
    assign SPSR_data = spsr_data_q;
    assign LR_we     = lr_we_q;
    assign LR_data   = lr_data_q;
    assign CPSR_we   = cpsr_we_q;
    assign CPSR_new  = cpsr_new_q;
    assign PC_we     = pc_we_q;
    assign PC_vector = pc_vector_q;
    assign Flush     = flush_q;

endmodule

// File: tb/tb_int_entry.sv
// -----------------------------------------------------------------------------
// tb_int_entry -- self-checking bench for int_entry.
// Reference model: a sequence position (0 = idle, 1..4 = entry step) plus the
// context captured at the take; expected outputs per step come from the
// architectural rules of interrupt entry.
// -----------------------------------------------------------------------------
module tb_int_entry;

`ifdef INT_HIVEC_EN
    localparam logic [31:0] VBASE = 32'hFFFF0000;
`else
    localparam logic [31:0] VBASE = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        INT_irq, INT_fiq, Instr_boundary;
    logic [31:0] CPSR, Ret_addr;
    logic        INTA_irq, INTA_fiq, Stall, SPSR_we, LR_we, CPSR_we, PC_we, Flush;
    logic [4:0]  SPSR_mode;
    logic [31:0] SPSR_data, LR_data, CPSR_new, PC_vector;

    int tests = 0;
    int fails = 0;

    // model state
    int          m_pos = 0;
    bit          m_f   = 1'b0;
    logic [31:0] m_c   = '0;
    logic [31:0] m_r   = '0;

    always #5 clk = ~clk;

    int_entry dut (
        .clk            (clk),
        .Rst_n          (Rst_n),
        .INT_irq        (INT_irq),
        .INT_fiq        (INT_fiq),
        .CPSR           (CPSR),
        .Ret_addr       (Ret_addr),
        .Instr_boundary (Instr_boundary),
        .INTA_irq       (INTA_irq),
        .INTA_fiq       (INTA_fiq),
        .Stall          (Stall),
        .SPSR_we        (SPSR_we),
        .SPSR_mode      (SPSR_mode),
        .SPSR_data      (SPSR_data),
        .LR_we          (LR_we),
        .LR_data        (LR_data),
        .CPSR_we        (CPSR_we),
        .CPSR_new       (CPSR_new),
        .PC_we          (PC_we),
        .PC_vector      (PC_vector),
        .Flush          (Flush)
    );

    logic [140:0] obs_w;
    assign obs_w = {INTA_irq, INTA_fiq, Stall, SPSR_we, SPSR_mode, SPSR_data,
                    LR_we, LR_data, CPSR_we, CPSR_new, PC_we, PC_vector, Flush};

    function automatic logic [140:0] expect_out(int pos, bit f, logic [31:0] c, logic [31:0] r);
        logic        e_ii, e_if, e_st, e_sw, e_lw, e_cw, e_pw, e_fl;
        logic [4:0]  e_sm, mode;
        logic [31:0] e_sd, e_ld, e_cn, e_pv;
        e_ii = 0; e_if = 0; e_st = 0; e_sw = 0; e_lw = 0; e_cw = 0; e_pw = 0; e_fl = 0;
        e_sm = '0; e_sd = '0; e_ld = '0; e_cn = '0; e_pv = '0;
        mode = f ? 5'b10001 : 5'b10010;
        if (pos != 0) e_st = 1;
        if (pos == 1) begin
            e_if = f;
            e_ii = !f;
        end
        if (pos == 2) begin
            e_sw = 1; e_sm = mode; e_sd = c;
            e_lw = 1; e_ld = r + 32'd4;
        end
        if (pos == 3) begin
            e_cw = 1;
            e_cn = c;
            e_cn[4:0] = mode;
            e_cn[5] = 1'b0;
            e_cn[7] = 1'b1;
            if (f) e_cn[6] = 1'b1;
        end
        if (pos == 4) begin
            e_pw = 1; e_fl = 1;
            e_pv = VBASE + (f ? 32'h1C : 32'h18);
        end
        return {e_ii, e_if, e_st, e_sw, e_sm, e_sd, e_lw, e_ld, e_cw, e_cn, e_pw, e_pv, e_fl};
    endfunction

    task automatic chk(input string tag, input logic [140:0] obs, input logic [140:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // model update at the active edge, from the inputs being applied
    task automatic model_edge();
        bit tf, ti;
        tf = INT_fiq && !CPSR[6];
        ti = INT_irq && !CPSR[7];
        if (!Rst_n) m_pos = 0;
        else if (m_pos != 0) m_pos = (m_pos == 4) ? 0 : m_pos + 1;
        else if (Instr_boundary && (tf || ti)) begin
            m_pos = 1;
            m_f   = tf;
            m_c   = CPSR;
            m_r   = Ret_addr;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, obs_w, expect_out(m_pos, m_f, m_c, m_r));
    endtask

    task automatic set_in(input logic irq, input logic fiq, input logic [31:0] c,
                          input logic [31:0] r, input logic b);
        INT_irq = irq; INT_fiq = fiq; CPSR = c; Ret_addr = r; Instr_boundary = b;
    endtask

    int inta_cnt;

    initial begin
        Rst_n = 1'b0;
        set_in(0, 0, '0, '0, 0);
        #12;
        chk("reset_state", obs_w, '0);
        Rst_n = 1'b1;

        // basic IRQ entry; inputs scrambled after the take
        set_in(1, 0, 32'h10, 32'h100, 1);
        step("irq_ack");
        chk32("irq_inta", {31'd0, INTA_irq}, 32'd1);
        set_in(0, 1, 32'hFFFFFFFF, 32'h12345678, 1);
        step("irq_save");
        chk32("irq_lr", LR_data, 32'h104);
        chk32("irq_spsr", SPSR_data, 32'h10);
        step("irq_switch");
        chk32("irq_cpsr", CPSR_new, 32'h92);
        set_in(0, 0, 32'h10, 32'h0, 1);
        step("irq_jump");
        chk32("irq_pc", PC_vector, VBASE + 32'h18);
        step("irq_idle");

        // simultaneous FIQ and IRQ: FIQ wins
        set_in(1, 1, 32'h10, 32'h200, 1);
        step("fiq_ack");
        chk32("fiq_inta", {30'd0, INTA_fiq, INTA_irq}, 32'd2);
        set_in(1, 0, 32'hD1, 32'h0, 1);
        step("fiq_save");
        step("fiq_switch");
        chk32("fiq_cpsr", CPSR_new, 32'hD1);
        step("fiq_jump");
        chk32("fiq_pc", PC_vector, VBASE + 32'h1C);
        for (int i = 0; i < 3; i++) step("irq_masked");
        chk32("irq_masked_stall", {31'd0, Stall}, 32'd0);
        set_in(1, 0, 32'h10, 32'h300, 1);
        step("irq_after_fiq");
        chk32("irq_after_fiq_inta", {31'd0, INTA_irq}, 32'd1);
        set_in(0, 0, 32'h10, 32'h0, 1);
        for (int i = 0; i < 4; i++) step("irq_after_fiq_seq");

        // IRQ masked for 20 cycles
        inta_cnt = 0;
        set_in(1, 0, 32'h90, 32'h400, 1);
        for (int i = 0; i < 20; i++) begin
            step("masked20");
            inta_cnt += int'(INTA_irq) + int'(INTA_fiq) + int'(Stall);
        end
        chk32("masked20_none", inta_cnt, 0);

        // Instr_boundary low holds idle
        set_in(1, 1, 32'h10, 32'h400, 0);
        for (int i = 0; i < 3; i++) step("no_boundary");

        // LR wrap-around
        set_in(1, 0, 32'h10, 32'hFFFFFFFE, 1);
        step("wrap_ack");
        set_in(0, 0, 32'h10, 32'h0, 1);
        step("wrap_save");
        chk32("wrap_lr", LR_data, 32'h2);
        for (int i = 0; i < 3; i++) step("wrap_tail");

        // reset asserted before the SWITCH edge, held across it
        set_in(1, 0, 32'h10, 32'h500, 1);
        step("rst_ack");
        step("rst_save");
        #4;
        Rst_n = 1'b0;
        #1;
        chk("rst_immediate", obs_w, '0);
        step("rst_held");
        chk32("rst_no_cpsr_we", {31'd0, CPSR_we}, 32'd0);
        #2;
        Rst_n = 1'b1;
        step("rst_first_take");
        chk32("rst_first_take_inta", {31'd0, INTA_irq}, 32'd1);
        set_in(0, 0, 32'h10, 32'h0, 1);
        for (int i = 0; i < 4; i++) step("rst_tail");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] c;
            c = $urandom;
            if ($urandom_range(0, 1) == 0) c[7:6] = 2'b00;
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c, $urandom,
                   1'($urandom_range(0, 3) != 0));
            Rst_n = ($urandom_range(0, 49) != 0);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/int_entry.md
INT_ENTRY -- requirements
Module: int_entry

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port INT_irq, input, 1, latched IRQ request from the interrupt request stage.
REQ-004 SHALL have port INT_fiq, input, 1, latched FIQ request from the interrupt request stage.
REQ-005 SHALL have port CPSR, input, 32, current program status register.
REQ-006 SHALL have port Ret_addr, input, 32, address of the next instruction to execute.
REQ-007 SHALL have port Instr_boundary, input, 1, high when the pipeline may be interrupted this cycle.
REQ-008 SHALL have ports INTA_irq and INTA_fiq, output, 1 each, one-cycle acknowledge pulses.
REQ-009 SHALL have port Stall, output, 1, freeze pipeline while the sequence runs.
REQ-010 SHALL have ports SPSR_we (1), SPSR_mode (5), SPSR_data (32), output, banked SPSR write.
REQ-011 SHALL have ports LR_we (1), LR_data (32), output, banked LR write.
REQ-012 SHALL have ports CPSR_we (1), CPSR_new (32), output, CPSR write.
REQ-013 SHALL have ports PC_we (1), PC_vector (32), Flush (1), output, redirect and flush fetch.

Function
REQ-014 SHALL implement a one-hot FSM with states IDLE, ACK, SAVE, SWITCH, JUMP.
REQ-015 IDLE SHALL go to ACK when Instr_boundary=1 and a request is taken: FIQ if INT_fiq=1 and CPSR[6]=0, else IRQ if INT_irq=1 and CPSR[7]=0.
REQ-016 On simultaneous FIQ and IRQ, FIQ SHALL win; IRQ remains pending, untouched.
REQ-017 On the IDLE->ACK edge, the block SHALL latch type, CPSR and Ret_addr; later input changes SHALL not affect the sequence.
REQ-018 ACK SHALL assert INTA_fiq or INTA_irq (per latched type) for exactly one cycle.
REQ-019 SAVE SHALL pulse SPSR_we and LR_we: SPSR_data = latched CPSR; SPSR_mode/target mode = 5'b10001 (FIQ) or 5'b10010 (IRQ); LR_data = latched Ret_addr + 4, mod 2^32.
REQ-020 SWITCH SHALL pulse CPSR_we: CPSR_new = latched CPSR with [4:0]=target mode, [5]=0, [7]=1, [6]=1 for FIQ else unchanged; [31:8] unchanged.
REQ-021 JUMP SHALL pulse PC_we and Flush with PC_vector = base+0x1C (FIQ) or base+0x18 (IRQ), then return to IDLE.
REQ-022 Stall SHALL be 1 in ACK, SAVE, SWITCH, JUMP and 0 in IDLE; fixed latency: 4 cycles from take to IDLE.
REQ-023 Requests arriving while not in IDLE SHALL be ignored until IDLE; Instr_boundary=0 SHALL hold IDLE.
REQ-024 All write enables SHALL be single-cycle, mutually exclusive, registered (Moore) outputs; data outputs SHALL be 0 when their enable is 0.
REQ-025 Earliest re-take SHALL be the cycle after JUMP, evaluated against the live CPSR.

Reset
REQ-026 Rst_n=0 SHALL immediately force IDLE and drive every output to 0, including mid-sequence; partially completed writes SHALL not be retried or completed.
REQ-027 After Rst_n rises, the first take SHALL be possible on the next rising clk edge.

Configuration
REQ-028 Macro INT_HIVEC_EN defined: vector base = 32'hFFFF0000; undefined: base = 32'h00000000; no other behaviour differs.

Verification
REQ-029 INT_irq=1, CPSR=32'h00000010, Ret_addr=32'h100, boundary=1 -> INTA_irq pulse, LR_data=32'h104, SPSR_data=32'h10, CPSR_new=32'h92, PC_vector=32'h18 (32'hFFFF0018 with macro).
REQ-030 INT_fiq=INT_irq=1, CPSR=32'h10 -> INTA_fiq only, CPSR_new=32'hD1, PC_vector=32'h1C; IRQ taken no earlier than after FIQ sequence, only if CPSR[7] cleared externally.
REQ-031 INT_irq=1, CPSR[7]=1 for 20 cycles -> no INTA, Stall=0 throughout.
REQ-032 Ret_addr=32'hFFFFFFFE -> LR_data=32'h00000002.
REQ-033 Rst_n low during SWITCH -> all outputs 0 same cycle, CPSR_we never asserted, IDLE after release.
